seq_detect_mealy: RTL and testbench
===================================

// Module: seq_detect_mealy
// PURPOSE
//  - Mealy FSM serial pattern detector; default pattern 1101, overlapping matches allowed.
//  - Samples one bit of din per rising clk edge.
//  - y is combinational from current state and din; pulses in the cycle the final pattern bit is on din.
//  - Sits on a serial bit stream as a match-flag generator for downstream control logic.
// PARAMETERS
//  - PAT_LEN  4        pattern length in bits, range 2..16
//  - PATTERN  4'b1101  pattern; MSB is received first; width PAT_LEN
// PORTS
//  - clk       in   1        rising-edge clock; single clock domain
//  - rst       in   1        asynchronous, active-low reset (0 = reset)
//  - din       in   1        serial data bit, sampled at posedge clk
//  - y         out  1        match flag, Mealy (combinational)
//  - hit_cnt   out  16       match counter, present only with SEQ_DETECT_COUNT_EN
// BEHAVIOUR
//  - State = length of longest received suffix equal to a proper prefix of PATTERN (0..PAT_LEN-1).
//  - Reset: state 0, y = 0 for the whole time rst = 0, hit_cnt = 0.
//  - y = 1 iff rst = 1, state = PAT_LEN-1, and din = PATTERN[0]; else y = 0.
//  - No registered output; zero latency from din to y.
//  - Next state: append din to the current prefix.
//    - If it extends the prefix: state + 1.
//    - If it completes the pattern, or on mismatch: longest proper border (KMP failure function) of the resulting string.
//  - Transition table is computed at elaboration by a constant function; no runtime search.
//  - Default 1101 table (S0 = "", S1 = "1", S2 = "11", S3 = "110"):
//    - S0: 0->S0, 1->S1
//    - S1: 0->S0, 1->S2
//    - S2: 0->S3, 1->S2
//    - S3: 0->S0, 1->S1 with y = 1
//  - Overlap: the completing bit seeds the next match (1101101 gives two hits).
//  - Reset mid-operation: partial progress is discarded immediately (async). The first bit after rst rises starts from S0.
//  - Illegal state encoding recovers to S0 on the next edge.
//  - din is assumed stable around posedge; there is no internal synchroniser.
// CONFIGURATION
//  - Macro: SEQ_DETECT_COUNT_EN
//  - Defined:
//    - hit_cnt port exists.
//    - Increments by 1 on each posedge where y = 1.
//    - Saturates at 16'hFFFF.
//    - Clears to 0 asynchronously on rst = 0.
//  - Undefined: no hit_cnt port and no counter logic; detector behaviour is identical.
// TESTING
//  - Reset: hold rst = 0 while driving din = 1,1,0,1.
//    -> y stays 0, state stays S0, hit_cnt = 0.
//  - Basic: rst = 1, din = 1,1,0,1.
//    -> y = 1 only in the 4th cycle (while din = 1 in S3); y = 0 the cycle after.
//  - Overlap: din = 1,1,0,1,1,0,1.
//    -> y high on bits 4 and 7; hit_cnt = 2.
//  - Long stream: din = 00110011011010011010 (left bit first).
//    -> y high on bits 10, 13 and 19 only; hit_cnt = 3.
//  - Mid-reset: din = 1,1,0; pulse rst low for 3 ns between edges; then din = 1.
//    -> y = 0 and state = S1 (no false hit).
//  - Mealy timing: in S3, toggle din 0->1->0 between edges.
//    -> y follows din combinationally with no clock edge.

Source files
------------

// File: rtl/seq_detect_mealy_if.sv
// Serial detector bus: input bit stream, Mealy match flag and, with SEQ_DETECT_COUNT_EN,
// the saturating hit counter.
interface seq_detect_mealy_if;
    logic        din;
    logic        y;
`ifdef SEQ_DETECT_COUNT_EN
    logic [15:0] hit_cnt;

    modport master (output din, input y, input hit_cnt);
    modport slave  (input din, output y, output hit_cnt);
`else
    modport master (output din, input y);
    modport slave  (input din, output y);
`endif
endinterface

// File: rtl/seq_detect_mealy.sv
// Mealy serial pattern detector (overlapping matches, KMP transition table built at elaboration).
// Optional saturating hit counter enabled by defining SEQ_DETECT_COUNT_EN.
module seq_detect_mealy #(
    parameter int                  PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]  PATTERN = 4'b1101
) (
    input  logic              clk,
    input  logic              rst,
    seq_detect_mealy_if.slave bus
);

    localparam int SW     = (PAT_LEN <= 2) ? 1 : $clog2(PAT_LEN);
    localparam int NENC   = 2 ** SW;
    localparam int TBL_W  = 2 * NENC * SW;

    // Entry (s, b) holds the longest suffix of prefix(s)+b that is a proper prefix of PATTERN;
    // unused encodings map to state 0 so an upset state recovers on the next edge.
    function automatic logic [TBL_W-1:0] build_table();
        logic [TBL_W-1:0] tbl;
        logic [16:0]      str;
        int               best;
        bit               ok;
        tbl = '0;
        for (int s = 0; s < PAT_LEN; s++) begin
            for (int b = 0; b < 2; b++) begin
                str = '0;
                for (int j = 0; j < s; j++) str[j] = PATTERN[PAT_LEN-1-j];
                str[s] = b[0];
                best = 0;
                for (int k = 1; k <= s + 1; k++) begin
                    if (k < PAT_LEN) begin
                        ok = 1'b1;
                        for (int i = 0; i < k; i++)
                            if (str[s+1-k+i] != PATTERN[PAT_LEN-1-i]) ok = 1'b0;
                        if (ok) best = k;
                    end
                end
                tbl[(s*2+b)*SW +: SW] = SW'(best);
            end
        end
        return tbl;
    endfunction

    localparam logic [TBL_W-1:0] NXT_TBL = build_table();

    typedef enum logic [SW-1:0] {
        ST_EMPTY = SW'(0),
        ST_LAST  = SW'(PAT_LEN-1)
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   y_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_EMPTY;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_t'(NXT_TBL[(int'(state_q) * 2 + int'(bus.din)) * SW +: SW]);
        y_d     = 1'b0;
        if (rst && (state_q == ST_LAST) && (bus.din == PATTERN[0])) y_d = 1'b1;
    end

    assign bus.y = y_d;

`ifdef SEQ_DETECT_COUNT_EN
    logic [15:0] hit_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                hit_cnt_q <= '0;
        else if (y_d && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 16'd1;
    end

    assign bus.hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_seq_detect_mealy.sv
// Bench for seq_detect_mealy: directed scenarios plus random stream, scored against a
// sliding-window reference model through an expectation queue.
module tb_seq_detect_mealy;

    localparam int               PAT_LEN = 4;
    localparam logic [3:0]       PATTERN = 4'b1101;

    typedef struct {
        bit y;
        int cnt;
    } exp_t;

    logic clk;
    logic rst;
    seq_detect_mealy_if bus();

    seq_detect_mealy #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int   tests     = 0;
    int   fails     = 0;
    int   dut_hits  = 0;
    int   model_cnt = 0;
    bit   hist[$];
    exp_t exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // True when the last PAT_LEN received bits, ending with b, spell the pattern.
    function automatic bit would_match(input bit b);
        bit tmp[$];
        logic [3:0] pat;
        pat = PATTERN;
        if (!rst) return 1'b0;
        tmp = hist;
        tmp.push_back(b);
        while (tmp.size() > PAT_LEN) void'(tmp.pop_front());
        if (tmp.size() < PAT_LEN) return 1'b0;
        for (int i = 0; i < PAT_LEN; i++)
            if (tmp[i] != pat[PAT_LEN-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input bit b, output exp_t e);
        if (!rst) begin
            hist.delete();
            model_cnt = 0;
            e.y   = 1'b0;
            e.cnt = 0;
        end else begin
            e.y   = would_match(b);
            e.cnt = model_cnt;
            hist.push_back(b);
            if (hist.size() > PAT_LEN) void'(hist.pop_front());
            if (e.y && model_cnt < 65535) model_cnt++;
        end
    endtask

    task automatic send(input bit b, input bit r);
        exp_t e;
        @(posedge clk);
        #1;
        rst     = r;
        bus.din = b;
        model_step(b, e);
        exp_q.push_back(e);
    endtask

    task automatic pulse_reset(input bit b);
        exp_t e;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        bus.din = b;
        hist.delete();
        model_cnt = 0;
        #1;
        check("y_during_reset", int'(bus.y), 0);
`ifdef SEQ_DETECT_COUNT_EN
        check("hit_cnt_during_reset", int'(bus.hit_cnt), 0);
`endif
        #2;
        rst = 1'b1;
        model_step(b, e);
        exp_q.push_back(e);
    endtask

    task automatic mealy_toggle();
        exp_t e;
        @(posedge clk);
        #1;
        rst     = 1'b1;
        bus.din = 1'b0;
        #1 check("mealy_din0_a", int'(bus.y), int'(would_match(1'b0)));
        bus.din = 1'b1;
        #1 check("mealy_din1", int'(bus.y), int'(would_match(1'b1)));
        bus.din = 1'b0;
        #1 check("mealy_din0_b", int'(bus.y), int'(would_match(1'b0)));
        model_step(1'b0, e);
        exp_q.push_back(e);
    endtask

    task automatic seg_hits(input string name, input int start, input int req);
        @(negedge clk);
        #1;
        check(name, dut_hits - start, req);
    endtask

    // Monitor: the detector presents a flag every cycle, scored at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("y", int'(bus.y), int'(e.y));
                if (bus.y === 1'b1) dut_hits++;
`ifdef SEQ_DETECT_COUNT_EN
                check("hit_cnt", int'(bus.hit_cnt), e.cnt);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [19:0] stream;
        int          start;
        stream  = 20'b00110011011010011010;
        rst     = 1'b0;
        bus.din = 1'b1;
        @(negedge clk);
        check("reset_y", int'(bus.y), 0);
`ifdef SEQ_DETECT_COUNT_EN
        check("reset_hit_cnt", int'(bus.hit_cnt), 0);
`endif

        start = dut_hits;
        send(1, 0); send(1, 0); send(0, 0); send(1, 0);
        seg_hits("hold_reset_hits", start, 0);

        start = dut_hits;
        send(1, 1); send(1, 1); send(0, 1); send(1, 1); send(0, 1);
        seg_hits("basic_hits", start, 1);

        start = dut_hits;
        send(1, 1); send(1, 1); send(0, 1); send(1, 1); send(1, 1); send(0, 1); send(1, 1);
        seg_hits("overlap_hits", start, 2);

        start = dut_hits;
        for (int i = 19; i >= 0; i--) send(stream[i], 1);
        seg_hits("long_stream_hits", start, 3);

        start = dut_hits;
        send(1, 1); send(1, 1); send(0, 1);
        pulse_reset(1'b1);
        send(1, 1); send(0, 1); send(1, 1);
        seg_hits("mid_reset_hits", start, 1);

        send(1, 1); send(1, 1); send(0, 1);
        mealy_toggle();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 4) pulse_reset(1'($urandom_range(0, 1)));
            else if (i % 100 < 50)         send(($urandom_range(0, 3) != 0), 1);
            else                           send(1'($urandom_range(0, 1)), 1);
        end

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
